// File: rtl/mem_access_unit_if.sv
// Request/response and memory-side bus of mem_access_unit.
// The slave modport is the unit's view; master is the requester/memory view.
interface mem_access_unit_if;
   // Requester side
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        err;
   // Memory side
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, funct3, addr, wdata, mem_rdata,
      output req_ready, resp_valid, rdata, err, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req_valid, req_we, funct3, addr, wdata, mem_rdata,
      input  req_ready, resp_valid, rdata, err, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_access_unit.sv
// RISC-V style load/store unit in front of a single-cycle word memory.
// Loads read one word and extend the addressed lane; SW writes directly;
// SB/SH read-modify-write the containing word. Bad width codes and
// misaligned addresses are rejected without touching memory.
// Optional feature: define MEM_ACCESS_RANGE_CHECK_EN to also reject
// addresses outside 0x0000_2000..0x0000_2FFF.
module mem_access_unit (
   input logic             clk,
   input logic             rstn,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

   localparam logic [2:0] F3Byte  = 3'b000;
   localparam logic [2:0] F3Half  = 3'b001;
   localparam logic [2:0] F3Word  = 3'b010;
   localparam logic [2:0] F3ByteU = 3'b100;
   localparam logic [2:0] F3HalfU = 3'b101;

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        accept;
   logic        code_ok;
   logic        misaligned;
   logic        range_ok;
   logic        req_bad;
   logic [31:0] word_addr;

   // Extract and extend the addressed lane of a fetched word.
   function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      unique case (f3)
         F3Byte:  res = {{24{b[7]}}, b};
         F3Half:  res = {{16{h[15]}}, h};
         F3ByteU: res = {24'b0, b};
         F3HalfU: res = {16'b0, h};
         default: res = word;
      endcase
      return res;
   endfunction

   // Replace only the addressed byte/halfword lane of the buffered word.
   function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word,
                                               input logic [31:0] data);
      logic [31:0] res;
      res = word;
      if (f3 == F3Half) begin
         if (lane[1]) res[31:16] = data[15:0];
         else         res[15:0]  = data[15:0];
      end else begin
         res[{lane, 3'b000} +: 8] = data[7:0];
      end
      return res;
   endfunction

   assign accept    = bus.req_valid && (state_q == StIdle);
   assign word_addr = {addr_q[31:2], 2'b00};

   // Classify the incoming request: legal width code, alignment, address range.
   always_comb begin
      code_ok    = 1'b0;
      misaligned = 1'b0;
      if (bus.req_we) begin
         code_ok = (bus.funct3 == F3Byte) || (bus.funct3 == F3Half) ||
                   (bus.funct3 == F3Word);
      end else begin
         code_ok = (bus.funct3 == F3Byte)  || (bus.funct3 == F3Half) ||
                   (bus.funct3 == F3Word)  || (bus.funct3 == F3ByteU) ||
                   (bus.funct3 == F3HalfU);
      end
      // funct3[1:0] encodes size for both signed and unsigned variants
      if (bus.funct3[1:0] == 2'b01) misaligned = bus.addr[0];
      if (bus.funct3[1:0] == 2'b10) misaligned = (bus.addr[1:0] != 2'b00);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
      range_ok = (bus.addr >= 32'h0000_2000) && (bus.addr <= 32'h0000_2FFF);
`else
      range_ok = 1'b1;
`endif
      req_bad = !code_ok || misaligned || !range_ok;
   end

   // Next-state, request latching and memory-side outputs.
   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      funct3_d      = funct3_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      buf_d         = buf_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      bus.mem_we    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               we_d     = bus.req_we;
               funct3_d = bus.funct3;
               addr_d   = bus.addr;
               wdata_d  = bus.wdata;
               if (req_bad) begin
                  // Rejected: respond next cycle, memory untouched
                  state_d = StResp;
                  err_d   = 1'b1;
                  rdata_d = 32'h0;
               end else if (bus.req_we && (bus.funct3 == F3Word)) begin
                  state_d = StWr;
               end else begin
                  // Loads and sub-word stores both need the current word
                  state_d = StRd;
               end
            end
         end
         StRd: begin
            bus.mem_addr = word_addr;
            buf_d        = bus.mem_rdata;
            if (we_q) begin
               state_d = StWr;
            end else begin
               state_d = StResp;
               rdata_d = load_extend(funct3_q, addr_q[1:0], bus.mem_rdata);
               err_d   = 1'b0;
            end
         end
         StWr: begin
            bus.mem_addr  = word_addr;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = (funct3_q == F3Word) ? wdata_q :
                            store_merge(funct3_q, addr_q[1:0], buf_q, wdata_q);
            state_d       = StResp;
            rdata_d       = 32'h0;
            err_d         = 1'b0;
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Handshake and result outputs; rdata/err only change on entry to StResp.
   always_comb begin
      bus.req_ready  = (state_q == StIdle);
      bus.resp_valid = (state_q == StResp);
      bus.rdata      = rdata_q;
      bus.err        = err_q;
   end

   // State and datapath registers; reset abandons any request in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         buf_q    <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         buf_q    <= buf_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and a
// response scoreboard (result, error flag, latency, write count).
module tb_mem_access_unit;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Word memory covering 0x0000..0x3FFF
   logic [31:0] mem [0:4095];
   int          we_count   = 0;
   int          resp_count = 0;
   logic [31:0] last_waddr = 32'h0;

   always_comb bus.mem_rdata = mem[bus.mem_addr[13:2]];

   always @(posedge clk) begin
      if (bus.mem_we) begin
         mem[bus.mem_addr[13:2]] <= bus.mem_wdata;
         we_count                <= we_count + 1;
         last_waddr              <= bus.mem_addr;
      end
      if (bus.resp_valid) resp_count <= resp_count + 1;
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          wes;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request (called at a negedge), then wait for and score its response.
   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int exp_wes);
      exp_t e;
      int   cyc;
      int   snap;
      logic seen;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.funct3    = f3;
      bus.addr      = a;
      bus.wdata     = wd;
      cyc = 0;
      while (bus.req_ready !== 1'b1 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, ":ready"}, {31'b0, bus.req_ready}, 32'd1);
      snap = we_count;
      @(posedge clk);
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.lat   = exp_lat;
      e.wes   = exp_wes;
      sb.push_back(e);
      // Drop the request and scramble inputs: the unit must use latched copies
      #1;
      bus.req_valid = 1'b0;
      bus.req_we    = ~we;
      bus.funct3    = 3'($urandom);
      bus.addr      = $urandom;
      bus.wdata     = $urandom;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 10) begin
         @(negedge clk);
         cyc++;
         seen = bus.resp_valid;
      end
      e = sb.pop_front();
      chk({tag, ":latency"}, cyc, e.lat);
      chk({tag, ":rdata"}, bus.rdata, e.rdata);
      chk({tag, ":err"}, {31'b0, bus.err}, {31'b0, e.err});
      chk({tag, ":mem_we_count"}, we_count - snap, e.wes);
   endtask

   initial begin
      int snap_we;
      int snap_resp;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.funct3    = 3'b000;
      bus.addr      = 32'h0;
      bus.wdata     = 32'h0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst:ready", {31'b0, bus.req_ready}, 32'd1);
      chk("rst:resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      chk("rst:mem_we", {31'b0, bus.mem_we}, 32'd0);
      chk("rst:rdata", bus.rdata, 32'h0);
      chk("rst:err", {31'b0, bus.err}, 32'd0);
      chk("rst:mem_addr", bus.mem_addr, 32'h0);
      rstn = 1'b1;
      @(negedge clk);

      // Preload via SW, then loads of every width
      do_req("sw_2000", 1'b1, 3'b010, 32'h2000, 32'h8765_4321, 32'h0, 1'b0, 2, 1);
      chk("sw_2000:waddr", last_waddr, 32'h2000);
      do_req("lw_2000", 1'b0, 3'b010, 32'h2000, 32'h0, 32'h8765_4321, 1'b0, 2, 0);
      do_req("lb_2003", 1'b0, 3'b000, 32'h2003, 32'h0, 32'hFFFF_FF87, 1'b0, 2, 0);
      // One-cycle pulse and held result while idle
      @(negedge clk);
      chk("lb_2003:pulse_low", {31'b0, bus.resp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      chk("lb_2003:rdata_hold", bus.rdata, 32'hFFFF_FF87);
      do_req("lbu_2003", 1'b0, 3'b100, 32'h2003, 32'h0, 32'h0000_0087, 1'b0, 2, 0);
      do_req("lh_2002", 1'b0, 3'b001, 32'h2002, 32'h0, 32'hFFFF_8765, 1'b0, 2, 0);
      do_req("lhu_2000", 1'b0, 3'b101, 32'h2000, 32'h0, 32'h0000_4321, 1'b0, 2, 0);

      // Sub-word stores: read-modify-write of the containing word
      do_req("sw_2004", 1'b1, 3'b010, 32'h2004, 32'h1122_3344, 32'h0, 1'b0, 2, 1);
      do_req("sb_2005", 1'b1, 3'b000, 32'h2005, 32'hFFFF_FFAB, 32'h0, 1'b0, 3, 1);
      chk("sb_2005:mem", mem[12'h801], 32'h1122_AB44);
      do_req("lw_2004a", 1'b0, 3'b010, 32'h2004, 32'h0, 32'h1122_AB44, 1'b0, 2, 0);
      do_req("sh_2006", 1'b1, 3'b001, 32'h2006, 32'h5555_BEEF, 32'h0, 1'b0, 3, 1);
      do_req("lw_2004b", 1'b0, 3'b010, 32'h2004, 32'h0, 32'hBEEF_AB44, 1'b0, 2, 0);

      // Rejected requests: misaligned and illegal width codes
      do_req("lw_2002_mis", 1'b0, 3'b010, 32'h2002, 32'h0, 32'h0, 1'b1, 1, 0);
      repeat (2) @(negedge clk);
      chk("lw_2002_mis:err_hold", {31'b0, bus.err}, 32'd1);
      do_req("lh_2001_mis", 1'b0, 3'b001, 32'h2001, 32'h0, 32'h0, 1'b1, 1, 0);
      do_req("sh_2003_mis", 1'b1, 3'b001, 32'h2003, 32'h1234, 32'h0, 1'b1, 1, 0);
      do_req("ld_f3_011", 1'b0, 3'b011, 32'h2000, 32'h0, 32'h0, 1'b1, 1, 0);
      do_req("st_f3_100", 1'b1, 3'b100, 32'h2000, 32'h99, 32'h0, 1'b1, 1, 0);
      do_req("lw_after_err", 1'b0, 3'b010, 32'h2000, 32'h0, 32'h8765_4321, 1'b0, 2, 0);

      // Address range
`ifdef MEM_ACCESS_RANGE_CHECK_EN
      do_req("sw_3000", 1'b1, 3'b010, 32'h3000, 32'h5A5A_5A5A, 32'h0, 1'b1, 1, 0);
`else
      do_req("sw_3000", 1'b1, 3'b010, 32'h3000, 32'h5A5A_5A5A, 32'h0, 1'b0, 2, 1);
      chk("sw_3000:waddr", last_waddr, 32'h3000);
`endif

      // Reset while an SH sits in RD: no write, no response
      @(negedge clk);
      snap_we       = we_count;
      snap_resp     = resp_count;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.funct3    = 3'b001;
      bus.addr      = 32'h2004;
      bus.wdata     = 32'h0000_1234;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid:rd_addr", bus.mem_addr, 32'h2004);
      rstn = 1'b0;
      #1;
      chk("rst_mid:ready", {31'b0, bus.req_ready}, 32'd1);
      chk("rst_mid:mem_we", {31'b0, bus.mem_we}, 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_mid:we_count", we_count - snap_we, 32'd0);
      chk("rst_mid:resp_count", resp_count - snap_resp, 32'd0);
      chk("rst_mid:ready_after", {31'b0, bus.req_ready}, 32'd1);
      chk("rst_mid:mem", mem[12'h801], 32'hBEEF_AB44);
      do_req("lw_2004c", 1'b0, 3'b010, 32'h2004, 32'h0, 32'hBEEF_AB44, 1'b0, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk in 1, clock, rising-edge active.
REQ-002 SHALL have ports: rstn in 1, reset, asynchronous, active-low.
REQ-003 SHALL have ports: req_valid in 1, request present; req_ready out 1, request accepted when both high.
REQ-004 SHALL have ports: req_we in 1 (1=store), funct3 in 3 (RISC-V load/store width code), addr in 32 (byte address), wdata in 32 (store data).
REQ-005 SHALL have ports: resp_valid out 1 (one-cycle completion pulse), rdata out 32 (extended load data), err out 1 (request rejected).
REQ-006 SHALL have memory-side ports: mem_addr out 32 (word-aligned byte address), mem_wdata out 32, mem_we out 1, mem_rdata in 32 (combinational read data for mem_addr).

Function
REQ-007 SHALL use FSM states IDLE, RD, WR, RESP; req_ready = (state==IDLE), combinational.
REQ-008 SHALL, on accept in IDLE, latch req_we, funct3, addr, wdata; later input changes have no effect.
REQ-009 SHALL decode loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other code sets err.
REQ-010 SHALL set err on misalignment: halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-011 SHALL transition on accept: err case -> RESP; load -> RD; SW -> WR; SB/SH -> RD.
REQ-012 SHALL in RD: capture mem_rdata into internal buffer; load -> RESP, SB/SH -> WR.
REQ-013 SHALL in WR: assert mem_we for exactly that one cycle, then -> RESP.
REQ-014 SHALL in RESP: pulse resp_valid one cycle, -> IDLE.
REQ-015 SHALL drive mem_addr = {latched addr[31:2], 2'b00} in RD and WR, 0 otherwise.
REQ-016 SHALL use little-endian byte lanes: lane = addr[1:0]; halfword lane = addr[1].
REQ-017 SHALL sign-extend LB/LH and zero-extend LBU/LHU from the selected lane; LW unmodified.
REQ-018 SHALL drive mem_wdata as: SW = wdata; SB/SH = buffered word with only the addressed lane(s) replaced by wdata[7:0]/[15:0].
REQ-019 SHALL, for an err request, never assert mem_we; rdata = 0.
REQ-020 SHALL hold rdata and err stable from RESP until the next RESP.
REQ-021 SHALL give latencies (accept edge to resp_valid high): load 2 cycles, SW 2, SB/SH 3, err 1.
REQ-022 SHALL ignore req_valid when req_ready=0; requester holds request; back-to-back accept possible in the cycle after RESP.

Reset
REQ-023 SHALL on rstn low immediately force state IDLE, req_ready=1, resp_valid=0, mem_we=0, rdata=0, err=0, internal buffers 0.
REQ-024 SHALL abort any in-flight request on reset with no memory write and no resp_valid.

Configuration
REQ-025 SHALL compile in, when MEM_ACCESS_RANGE_CHECK_EN is defined, the check 0x0000_2000 <= addr <= 0x0000_2FFF; out-of-range requests set err per REQ-019.
REQ-026 SHALL, without MEM_ACCESS_RANGE_CHECK_EN, pass any address through unchecked.

Verification
REQ-027 SHALL cover LW: memory word 0x2000 = 0x8765_4321; load funct3=010 addr=0x2000 -> resp_valid 2 cycles after accept, rdata=0x8765_4321, err=0.
REQ-028 SHALL cover LB/LBU: same word, addr=0x2003 -> LB rdata=0xFFFF_FF87; LBU rdata=0x0000_0087.
REQ-029 SHALL cover SB: word 0x2004 = 0x1122_3344; SB addr=0x2005 wdata=0xAB -> single mem_we pulse, word becomes 0x1122_AB44, resp 3 cycles after accept.
REQ-030 SHALL cover misalignment: LW addr=0x2002 -> err=1, resp 1 cycle after accept, no mem_we.
REQ-031 SHALL cover reset mid-op: SH accepted, rstn low during RD -> mem_we never asserts, memory unchanged, req_ready=1 after release.
REQ-032 SHALL cover range: with MEM_ACCESS_RANGE_CHECK_EN, SW addr=0x3000 -> err=1, no mem_we; without it, mem_we pulses with mem_addr=0x3000.
